// File: rtl/wb_seq_pkg.sv
// Shared definitions for the Wishbone command sequencer: opcodes, instruction
// field layout helpers and FSM state encoding.
package wb_seq_pkg;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_POLL  = 2'd2;
    localparam logic [1:0] OP_HALT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_BUS,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } state_e;

    // Instruction word, MSB first: {OP[2], CS, SEL, TGT, ADR, DATA, MASK}
    function automatic int unsigned instr_width(input int unsigned cs_w, input int unsigned tgt_w,
                                                input int unsigned adr_w, input int unsigned data_w);
        return 3 + cs_w + tgt_w + adr_w + 2 * data_w;
    endfunction

    function automatic int unsigned adr_lsb(input int unsigned data_w);
        return 2 * data_w;
    endfunction

    function automatic int unsigned tgt_lsb(input int unsigned adr_w, input int unsigned data_w);
        return adr_lsb(data_w) + adr_w;
    endfunction

    function automatic int unsigned sel_bit(input int unsigned tgt_w, input int unsigned adr_w,
                                            input int unsigned data_w);
        return tgt_lsb(adr_w, data_w) + tgt_w;
    endfunction

    function automatic int unsigned cs_lsb(input int unsigned tgt_w, input int unsigned adr_w,
                                           input int unsigned data_w);
        return sel_bit(tgt_w, adr_w, data_w) + 1;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned cs_w, input int unsigned tgt_w,
                                           input int unsigned adr_w, input int unsigned data_w);
        return cs_lsb(tgt_w, adr_w, data_w) + cs_w;
    endfunction

endpackage

// File: rtl/wb_cmd_rom.sv
// Case-table program ROM for the command sequencer; IMAGE selects the program.
// Combinational read so the word is valid in the same cycle as the address.
module wb_cmd_rom
    import wb_seq_pkg::*;
#(
    parameter int unsigned PC_W    = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADR_W   = 3,
    parameter int unsigned NUM_TGT = 2,
    parameter int unsigned CS_W    = 2,
    parameter int unsigned IMAGE   = 0,
    localparam int unsigned TGT_W   = $clog2(NUM_TGT),
    localparam int unsigned INSTR_W = instr_width(CS_W, TGT_W, ADR_W, DATA_W)
) (
    input  logic [PC_W-1:0]    adr,
    output logic [INSTR_W-1:0] dat
);

    function automatic logic [INSTR_W-1:0] enc(input logic [1:0] op, input logic [CS_W-1:0] cs,
                                               input logic sel, input logic [TGT_W-1:0] tgt,
                                               input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d,
                                               input logic [DATA_W-1:0] m);
        return {op, cs, sel, tgt, a, d, m};
    endfunction

    // Image 0: bring-up sequence (write, read, poll, halt); image 1: 16 writes, no halt
    always_comb begin
        dat = enc(OP_HALT, '0, 1'b0, '0, '0, '0, '0);
        if (IMAGE == 0) begin
            case (adr)
                PC_W'(0): dat = enc(OP_WRITE, CS_W'(1), 1'b0, TGT_W'(0), ADR_W'(0), DATA_W'(8'h50), '0);
                PC_W'(1): dat = enc(OP_READ,  CS_W'(2), 1'b1, TGT_W'(1), ADR_W'(1), '0, '0);
                PC_W'(2): dat = enc(OP_POLL,  CS_W'(1), 1'b0, TGT_W'(0), ADR_W'(2),
                                    DATA_W'(8'h04), DATA_W'(8'h04));
                default: ;
            endcase
        end else begin
            dat = enc(OP_WRITE, CS_W'(1), 1'b0, TGT_W'(adr[0]), ADR_W'(adr), DATA_W'(adr), '0);
        end
    end

endmodule

// File: rtl/wb_cmd_sequencer.sv
// Programmable classic-Wishbone master: fetches instructions from an external
// ROM and issues WRITE / READ / POLL cycles with per-cycle ack timeout.
module wb_cmd_sequencer
    import wb_seq_pkg::*;
#(
    parameter int unsigned PC_W    = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADR_W   = 3,
    parameter int unsigned NUM_TGT = 2,
    parameter int unsigned CS_W    = 2,
    parameter int unsigned TMO     = 255,
    localparam int unsigned TGT_W   = $clog2(NUM_TGT),
    localparam int unsigned INSTR_W = instr_width(CS_W, TGT_W, ADR_W, DATA_W)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic [PC_W-1:0]    prog_adr_o,
    input  logic [INSTR_W-1:0] prog_dat_i,
    output logic               cyc_o,
    output logic [NUM_TGT-1:0] stb_o,
    output logic [ADR_W-1:0]   adr_o,
    output logic               we_o,
    output logic [DATA_W-1:0]  dat_o,
    input  logic [DATA_W-1:0]  dat_i,
    input  logic               ack_i,
    output logic               dat_i_sel,
    output logic [CS_W-1:0]    spi_cs,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [DATA_W-1:0]  rd_data_o,
    output logic [PC_W-1:0]    pc_o
);

    localparam int unsigned CNT_W    = $clog2(TMO + 1);
    localparam int unsigned ADR_LSB  = adr_lsb(DATA_W);
    localparam int unsigned TGT_LSB  = tgt_lsb(ADR_W, DATA_W);
    localparam int unsigned SEL_BIT  = sel_bit(TGT_W, ADR_W, DATA_W);
    localparam int unsigned CS_LSB   = cs_lsb(TGT_W, ADR_W, DATA_W);
    localparam int unsigned OP_LSB   = op_lsb(CS_W, TGT_W, ADR_W, DATA_W);

    state_e              state;
    logic [PC_W-1:0]     pc_q;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   mask_q;
    logic [CNT_W-1:0]    tmo_cnt;
    logic                poll_miss;

    logic [1:0]          f_op;
    logic [CS_W-1:0]     f_cs;
    logic                f_sel;
    logic [TGT_W-1:0]    f_tgt;
    logic [ADR_W-1:0]    f_adr;
    logic [DATA_W-1:0]   f_data;
    logic [DATA_W-1:0]   f_mask;
    logic [NUM_TGT-1:0]  f_stb;

    assign f_op   = prog_dat_i[OP_LSB +: 2];
    assign f_cs   = prog_dat_i[CS_LSB +: CS_W];
    assign f_sel  = prog_dat_i[SEL_BIT];
    assign f_tgt  = prog_dat_i[TGT_LSB +: TGT_W];
    assign f_adr  = prog_dat_i[ADR_LSB +: ADR_W];
    assign f_data = prog_dat_i[DATA_W +: DATA_W];
    assign f_mask = prog_dat_i[0 +: DATA_W];

    // Target codes >= NUM_TGT select nothing, so such a cycle can only time out
    always_comb begin
        f_stb = '0;
        for (int i = 0; i < int'(NUM_TGT); i++) begin
            f_stb[i] = (f_tgt == TGT_W'(i));
        end
    end

    assign prog_adr_o = pc_q;
    assign pc_o       = pc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            pc_q      <= '0;
            op_q      <= OP_WRITE;
            data_q    <= '0;
            mask_q    <= '0;
            tmo_cnt   <= '0;
            poll_miss <= 1'b0;
            cyc_o     <= 1'b0;
            stb_o     <= '0;
            adr_o     <= '0;
            we_o      <= 1'b0;
            dat_o     <= '0;
            dat_i_sel <= 1'b0;
            spi_cs    <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            rd_data_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        err_o  <= 1'b0;
                        pc_q   <= '0;
                        busy_o <= 1'b1;
                        state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    op_q      <= f_op;
                    data_q    <= f_data;
                    mask_q    <= f_mask;
                    spi_cs    <= f_cs;
                    dat_i_sel <= f_sel;
                    if (f_op == OP_HALT) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        cyc_o   <= 1'b1;
                        stb_o   <= f_stb;
                        adr_o   <= f_adr;
                        we_o    <= (f_op == OP_WRITE);
                        dat_o   <= f_data;
                        tmo_cnt <= '0;
                        state   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // An ack in the last allowed cycle takes priority over the timeout
                    if (ack_i) begin
                        cyc_o     <= 1'b0;
                        stb_o     <= '0;
                        we_o      <= 1'b0;
                        if (op_q != OP_WRITE) begin
                            rd_data_o <= dat_i;
                        end
                        poll_miss <= (op_q == OP_POLL) && (((dat_i ^ data_q) & mask_q) != '0);
                        state     <= ST_NEXT;
                    end else if (tmo_cnt == CNT_W'(TMO - 1)) begin
                        cyc_o  <= 1'b0;
                        stb_o  <= '0;
                        we_o   <= 1'b0;
                        err_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_ERR;
                    end else if (tmo_cnt != CNT_W'(TMO)) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (poll_miss) begin
                        state <= ST_FETCH;
                    end else if (pc_q == {PC_W{1'b1}}) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        pc_q  <= pc_q + PC_W'(1);
                        state <= ST_FETCH;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// Scoreboard bench for wb_cmd_sequencer: a program-level model queues expected
// bus transactions and completions; a monitor compares what the DUT drives.
module tb_wb_cmd_sequencer;

    localparam int unsigned PC_W    = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADR_W   = 3;
    localparam int unsigned NUM_TGT = 2;
    localparam int unsigned CS_W    = 2;
    localparam int unsigned TMO     = 4;
    localparam int unsigned INSTR_W = 25;
    localparam int          NOACK   = 255;

    typedef struct packed {
        logic       is_done;
        logic [1:0] stb;
        logic [2:0] adr;
        logic       we;
        logic [7:0] dat;
        logic [1:0] cs;
        logic       sel;
        logic [3:0] pc;
        logic [7:0] len;
        logic       to_err;
        logic [7:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start_i, ack_i, use_rom;
    logic [PC_W-1:0] prog_adr_o, pc_o;
    logic [INSTR_W-1:0] prog_dat_i, rom_dat;
    logic cyc_o, we_o, dat_i_sel, busy_o, done_o, err_o;
    logic [NUM_TGT-1:0] stb_o;
    logic [ADR_W-1:0] adr_o;
    logic [DATA_W-1:0] dat_o, dat_i, rd_data_o;
    logic [CS_W-1:0] spi_cs;

    logic [INSTR_W-1:0] prog [16];
    int          s_lat [128];
    logic [7:0]  s_dat [128];
    exp_t        exp_q [$];
    logic [7:0]  model_rd;
    int total = 0;
    int bad = 0;
    bit mon_en;

    always #5 clk = ~clk;

    wb_cmd_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W), .ADR_W(ADR_W), .NUM_TGT(NUM_TGT),
                       .CS_W(CS_W), .TMO(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .prog_adr_o(prog_adr_o),
        .prog_dat_i(prog_dat_i), .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .we_o(we_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .dat_i_sel(dat_i_sel), .spi_cs(spi_cs),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rd_data_o(rd_data_o), .pc_o(pc_o)
    );

    wb_cmd_rom #(.PC_W(PC_W), .DATA_W(DATA_W), .ADR_W(ADR_W), .NUM_TGT(NUM_TGT),
                 .CS_W(CS_W), .IMAGE(0)) u_rom (.adr(prog_adr_o), .dat(rom_dat));

    assign prog_dat_i = use_rom ? rom_dat : prog[prog_adr_o];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [24:0] enc(input logic [1:0] op, input logic [1:0] cs, input logic sel,
                                        input logic tgt, input logic [2:0] a, input logic [7:0] d,
                                        input logic [7:0] m);
        return {op, cs, sel, tgt, a, d, m};
    endfunction

    // Program-level reference: walk the program, deciding slave behaviour per transaction
    function automatic void plan_run(input bit scripted, input bit allow_to);
        int pc = 0;
        int n = 0;
        logic [24:0] w;
        logic [1:0] op;
        logic [7:0] data, mask;
        exp_t e;
        bit miss;
        for (int step = 0; step < 120; step++) begin
            w = prog[pc];
            op = w[24:23];
            data = w[15:8];
            mask = w[7:0];
            e = '0;
            e.pc = 4'(pc);
            if (op == 2'd3) begin
                e.is_done = 1'b1;
                exp_q.push_back(e);
                break;
            end
            if (!scripted) begin
                s_lat[n] = (allow_to && $urandom_range(15) == 0) ? NOACK : int'($urandom_range(TMO - 1));
                s_dat[n] = 8'($urandom);
                if (op == 2'd2 && ($urandom_range(1) == 1 || n >= 100))
                    s_dat[n] = (data & mask) | (s_dat[n] & ~mask);
            end
            e.stb = 2'b01 << w[19];
            e.adr = w[18:16];
            e.we  = (op == 2'd0);
            e.dat = data;
            e.cs  = w[22:21];
            e.sel = w[20];
            if (s_lat[n] == NOACK) begin
                e.len = 8'(TMO);
                e.to_err = 1'b1;
                e.rd = model_rd;
                exp_q.push_back(e);
                break;
            end
            e.len = 8'(s_lat[n] + 1);
            if (op != 2'd0) model_rd = s_dat[n];
            e.rd = model_rd;
            exp_q.push_back(e);
            miss = (op == 2'd2) && ((s_dat[n] & mask) != (data & mask));
            n++;
            if (!miss) begin
                if (pc == 15) begin
                    e = '0;
                    e.is_done = 1'b1;
                    e.pc = 4'd15;
                    exp_q.push_back(e);
                    break;
                end
                pc++;
            end
        end
    endfunction

    // Slave: acks the n-th cycle after s_lat[n] extra wait cycles, NOACK never acks
    int s_n = 0, s_cnt = 0;
    bit s_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            s_n = 0; s_prev = 1'b0; ack_i = 1'b0;
        end else begin
            if (start_i && !busy_o) s_n = 0;
            if (cyc_o) begin
                s_cnt = s_prev ? s_cnt + 1 : 0;
                ack_i = (s_lat[s_n] != NOACK) && (s_cnt == s_lat[s_n]);
                dat_i = s_dat[s_n];
            end else begin
                if (s_prev) s_n++;
                ack_i = 1'b0;
                dat_i = 8'($urandom);
            end
            s_prev = cyc_o;
        end
    end

    // Monitor: pop and compare on each transaction start/end and completion pulse
    exp_t m_cur;
    exp_t m_d;
    bit m_cyc = 1'b0, m_done = 1'b0, m_err = 1'b0, m_live = 1'b0, m_ok;
    int m_len = 0, m_idle = 100;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (cyc_o && !m_cyc) begin
                chk("idle_gap", 32'(m_idle >= 1), 32'd1);
                m_ok = (exp_q.size() != 0) && !exp_q[0].is_done;
                chk("txn_expected", 32'(m_ok), 32'd1);
                m_live = m_ok;
                m_len = 1;
                if (m_ok) begin
                    m_cur = exp_q.pop_front();
                    chk("stb", 32'(stb_o), 32'(m_cur.stb));
                    chk("adr", 32'(adr_o), 32'(m_cur.adr));
                    chk("we", 32'(we_o), 32'(m_cur.we));
                    if (m_cur.we) chk("dat_o", 32'(dat_o), 32'(m_cur.dat));
                    chk("spi_cs", 32'(spi_cs), 32'(m_cur.cs));
                    chk("dat_i_sel", 32'(dat_i_sel), 32'(m_cur.sel));
                    chk("pc", 32'(pc_o), 32'(m_cur.pc));
                    chk("busy_in_bus", 32'(busy_o), 32'd1);
                end
            end else if (cyc_o && m_live) begin
                m_len++;
                chk("stb_stable", 32'({stb_o, adr_o, we_o}), 32'({m_cur.stb, m_cur.adr, m_cur.we}));
            end
            if (!cyc_o && m_cyc && m_live) begin
                chk("cyc_len", 32'(m_len), 32'(m_cur.len));
                chk("stb_drop", 32'(stb_o), 32'd0);
                if (m_cur.to_err) begin
                    chk("err_on_timeout", 32'(err_o), 32'd1);
                    chk("busy_after_err", 32'(busy_o), 32'd0);
                end else begin
                    chk("rd_data", 32'(rd_data_o), 32'(m_cur.rd));
                end
            end
            if (err_o && !m_err)
                chk("err_rise_cause", 32'(m_cyc && !cyc_o && m_live && m_cur.to_err), 32'd1);
            if (done_o) begin
                chk("done_width", 32'(m_done), 32'd0);
                m_ok = (exp_q.size() != 0) && exp_q[0].is_done;
                chk("done_expected", 32'(m_ok), 32'd1);
                if (m_ok) begin
                    m_d = exp_q.pop_front();
                    chk("done_pc", 32'(pc_o), 32'(m_d.pc));
                    chk("done_busy", 32'(busy_o), 32'd0);
                    chk("done_err", 32'(err_o), 32'd0);
                end
            end
        end
        m_idle = cyc_o ? 0 : m_idle + 1;
        m_cyc = cyc_o;
        m_done = done_o;
        m_err = err_o;
    end

    task automatic fill_prog(input bit halts, input bit only_rw);
        for (int i = 0; i < 16; i++) begin
            int r;
            logic [1:0] op;
            r = int'($urandom_range(7));
            if (only_rw) op = 2'($urandom_range(1));
            else if (r < 3) op = 2'd0;
            else if (r < 5) op = 2'd1;
            else if (r < 7 || !halts) op = 2'd2;
            else op = 2'd3;
            prog[i] = enc(op, 2'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                          8'($urandom), 8'($urandom));
        end
    endtask

    task automatic run_prog(input bit rom, input bit poke_start);
        bit fin;
        use_rom = rom;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        chk("start_clears_err", 32'(err_o), 32'd0);
        chk("start_sets_busy", 32'(busy_o), 32'd1);
        fin = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done_o || err_o) begin
                fin = 1'b1;
                break;
            end
            start_i = poke_start && busy_o && ($urandom_range(5) == 0);
        end
        start_i = 1'b0;
        chk("run_finished", 32'(fin), 32'd1);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start_i = 1'b0; ack_i = 1'b0; dat_i = '0; use_rom = 1'b0;
        mon_en = 1'b1; model_rd = '0;
        for (int i = 0; i < 128; i++) begin s_lat[i] = 0; s_dat[i] = '0; end
        for (int i = 0; i < 16; i++) prog[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({cyc_o, stb_o, we_o, busy_o, done_o, err_o, dat_i_sel, spi_cs}), 32'd0);
        chk("rst_rd_pc", 32'({rd_data_o, pc_o, prog_adr_o}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Bring-up ROM: write, read 0xA5, poll 0x04 on third attempt (ack on last allowed cycle), halt at 3
        for (int i = 0; i < 16; i++) prog[i] = enc(2'd3, 2'd0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        prog[0] = enc(2'd0, 2'd1, 1'b0, 1'b0, 3'd0, 8'h50, 8'h00);
        prog[1] = enc(2'd1, 2'd2, 1'b1, 1'b1, 3'd1, 8'h00, 8'h00);
        prog[2] = enc(2'd2, 2'd1, 1'b0, 1'b0, 3'd2, 8'h04, 8'h04);
        s_lat[0] = 2; s_lat[1] = 1; s_lat[2] = 0; s_lat[3] = 0; s_lat[4] = int'(TMO) - 1;
        s_dat[0] = 8'h00; s_dat[1] = 8'hA5; s_dat[2] = 8'h00; s_dat[3] = 8'h00; s_dat[4] = 8'h04;
        plan_run(1'b1, 1'b0);
        run_prog(1'b1, 1'b0);
        chk("rd_after_rom", 32'(rd_data_o), 32'h04);

        // No ack: timeout after TMO cycles, err sticky, no done pulse
        prog[0] = enc(2'd0, 2'd3, 1'b0, 1'b1, 3'd5, 8'h3C, 8'h00);
        s_lat[0] = NOACK;
        plan_run(1'b1, 1'b0);
        run_prog(1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("err_sticky", 32'({err_o, busy_o}), 32'b10);

        // Full 16-entry program without halt ends after PC 15
        fill_prog(1'b0, 1'b1);
        plan_run(1'b0, 1'b0);
        run_prog(1'b0, 1'b0);

        // Random programs with timeouts, polls and start pulses while busy
        for (int r = 0; r < 12; r++) begin
            fill_prog(1'b1, 1'b0);
            plan_run(1'b0, 1'b1);
            run_prog(1'b0, 1'b1);
        end

        // Reset during a bus cycle drops cyc/stb at once; nothing resumes afterwards
        mon_en = 1'b0;
        prog[0] = enc(2'd0, 2'd1, 1'b0, 1'b1, 3'd2, 8'h77, 8'h00);
        s_lat[0] = NOACK;
        use_rom = 1'b0;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cyc_o) begin seen = 1'b1; break; end
        end
        chk("cyc_before_rst", 32'(seen), 32'd1);
        @(posedge clk); #2 rst = 1'b1;
        #1 chk("rst_async_cyc", 32'({cyc_o, stb_o}), 32'd0);
        chk("rst_async_state", 32'({busy_o, err_o, pc_o, rd_data_o}), 32'd0);
        @(negedge clk) rst = 1'b0;
        model_rd = '0;
        exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_resume", 32'({cyc_o, busy_o}), 32'd0);
        end
        mon_en = 1'b1;
        fill_prog(1'b1, 1'b0);
        plan_run(1'b0, 1'b0);
        run_prog(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
